// File: rtl/led_pulse_stretch_pkg.sv
// Shared helpers for the LED pulse stretcher and its timebase.
// Latency: none. This file holds compile-time functions only.
// Backpressure: not applicable.
package led_pulse_stretch_pkg;

    // Returns the number of bits needed to hold the values 0..n-1.
    // The result is never less than 1.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_pulse_stretch_tick_gen.sv
// tick_gen: free-running prescaler that produces a one-cycle TICK every DIV clocks.
// Latency: TICK is high while the count equals DIV-1. CLR or RST restarts the count from 0 on the next edge.
// Backpressure: none. The counter always runs.
// Ports: CLK clock, RST sync active-high reset, CLR sync restart, TICK one-cycle strobe.
module tick_gen
    import led_pulse_stretch_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic CLR,
    output logic TICK
);

    localparam int            CW   = cnt_w(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign TICK = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (CLR || TICK) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pulse_stretch.sv
// led_pulse_stretch: turns one-cycle event requests into visible LED pulses.
// Each pulse is ON for ON_TICKS ticks and is followed by an OFF_TICKS gap.
// Events that arrive while the LED is busy are queued in PEND, which saturates at 2^PEND_W-1.
// Latency: in IDLE, TRIG in cycle n gives LED=1 in cycle n+1. All outputs are registered.
// Backpressure: none. When the queue is full, an extra event is dropped and DROP pulses for one cycle.
// Ports: CLK, RST (sync active-high), TRIG event input; LED, BUSY, PEND (queue depth), DROP outputs.
module led_pulse_stretch
    import led_pulse_stretch_pkg::*;
#(
    parameter int CLK_HZ    = 125000000,
    parameter int TICK_HZ   = 40,
    parameter int ON_TICKS  = 8,
    parameter int OFF_TICKS = 4,
    parameter int PEND_W    = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              TRIG,
    output logic              LED,
    output logic              BUSY,
    output logic [PEND_W-1:0] PEND,
    output logic              DROP
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int TW  = cnt_w(max2(ON_TICKS, OFF_TICKS));

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        ON   = ST_ON,
        GAP  = ST_GAP
    } state_t;

    localparam logic [PEND_W-1:0] PMAX     = '1;
    localparam logic [TW-1:0]     ON_LAST  = TW'(ON_TICKS - 1);
    localparam logic [TW-1:0]     OFF_LAST = TW'(OFF_TICKS - 1);

    state_t            state_q, state_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              led_q, busy_q, drop_q, drop_d;
    logic              tick;
    logic              entry;
    logic              inc, dec;

    // The prescaler restarts on every state change.
    // This makes each phase last exactly its tick count times DIV cycles.
    tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .CLK  (CLK),
        .RST  (RST),
        .CLR  (entry),
        .TICK (tick)
    );

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        dec     = 1'b0;
        case (state_q)
            IDLE: begin
                // The event that starts the pulse is shown immediately.
                // It is never queued.
                if (TRIG) begin
                    state_d = ON;
                end
            end
            ON: begin
                if (tick) begin
                    if (tcnt_q == ON_LAST) begin
                        state_d = GAP;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (tcnt_q == OFF_LAST) begin
                        if (pend_q != '0) begin
                            state_d = ON;
                            dec     = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        entry = (state_d != state_q);
        if (entry) begin
            tcnt_d = '0;
        end
    end

    // Queue update.
    // If an event arrives in the same cycle that a queued event is consumed, the two cancel out.
    // This cannot cause a drop even when the queue is full.
    always_comb begin
        inc    = TRIG && (state_q != IDLE);
        pend_d = pend_q;
        drop_d = 1'b0;
        if (inc && !dec) begin
            if (pend_q == PMAX) begin
                drop_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_W'(1);
            end
        end else if (dec && !inc) begin
            pend_d = pend_q - PEND_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            tcnt_q  <= '0;
            pend_q  <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            pend_q  <= pend_d;
            led_q   <= (state_d == ON);
            busy_q  <= (state_d != IDLE);
            drop_q  <= drop_d;
        end
    end

    assign LED  = led_q;
    assign BUSY = busy_q;
    assign PEND = pend_q;
    assign DROP = drop_q;

endmodule
